ppu_write_ctrl: RTL

Host-side write path for the PPU memories: it is the writer feeding the tile buffer, tile graphics, sprite graphics, color palette and OAM RAMs that the PPU reads.
- The CPU streams 32-bit words over the Avalon-style `write`/`chipselect` port: a command word, then data words.
- The block decodes each command, auto-increments the target address, and queues each write in a FIFO.
- The FIFO drains into the selected RAM only while `vblank` is high, so CPU updates never collide with PPU line fetches.

---
 rtl/ppu_write_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ppu_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ppu_write_ctrl
// Description : Host write path into the PPU RAMs. Parses command/data words,
//               queues writes in a FIFO and drains them only during vblank.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_write_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] write_data,
    input  logic        write,
    input  logic        chipselect,
    input  logic        vblank,
    output logic        rw_tile_buffer,
    output logic        rw_tile_graphics,
    output logic        rw_sprite_graphics,
    output logic        rw_color_palettes,
    output logic        rw_OAM,
    output logic [8:0]  addr_tile_buffer,
    output logic [10:0] addr_tile_graphics,
    output logic [10:0] addr_sprite_graphics,
    output logic [2:0]  addr_color_palettes,
    output logic [7:0]  addr_OAM,
    output logic [31:0] write_data_tile_buffer,
    output logic [31:0] write_data_tile_graphics,
    output logic [31:0] write_data_sprite_graphics,
    output logic [23:0] write_data_color_palettes,
    output logic [31:0] write_data_OAM,
    output logic        fifo_full,
    output logic        overflow,
    output logic        bad_target
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                 c_ENTRY_W = 3 + 11 + 32;
    localparam logic [c_PTR_W:0]   c_DEPTH   = FIFO_DEPTH[c_PTR_W:0];
    localparam logic [2:0]         c_MAX_TGT = 3'd4;

    typedef enum logic [0:0] {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t                 r_state, w_state_next;
    logic [2:0]             r_target, w_target_next;
    logic [10:0]            r_addr, w_addr_next;
    logic [8:0]             r_remaining, w_remaining_next;
    logic                   w_beat, w_push, w_drop, w_bad_cmd, w_pop, w_space;

    logic [c_ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [c_PTR_W:0]       r_count, w_count_next;

    logic                   r_pop_valid;
    logic [c_ENTRY_W-1:0]   r_pop_entry;
    logic [2:0]             w_pop_tgt;
    logic [10:0]            w_pop_addr;
    logic [31:0]            w_pop_data;
    logic [9:0]             w_unused_bits;

    assign w_unused_bits = write_data[9:0];
    assign w_beat        = write && chipselect;
    // Space is judged on the pre-edge count; a same-cycle pop does not help.
    assign w_space       = (r_count < c_DEPTH);
    assign w_pop         = vblank && (r_count != '0);

    always_comb begin
        w_state_next     = r_state;
        w_target_next    = r_target;
        w_addr_next      = r_addr;
        w_remaining_next = r_remaining;
        w_push           = 1'b0;
        w_drop           = 1'b0;
        w_bad_cmd        = 1'b0;
        case (r_state)
            ST_CMD: begin
                if (w_beat) begin
                    w_target_next    = write_data[31:29];
                    w_addr_next      = write_data[28:18];
                    w_remaining_next = {1'b0, write_data[17:10]} + 9'd1;
                    w_bad_cmd        = (write_data[31:29] > c_MAX_TGT);
                    w_state_next     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    w_addr_next      = r_addr + 11'd1;
                    w_remaining_next = r_remaining - 9'd1;
                    if (r_target <= c_MAX_TGT) begin
                        w_push = w_space;
                        w_drop = !w_space;
                    end
                    if (r_remaining == 9'd1) begin
                        w_state_next = ST_CMD;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CMD;
            r_target    <= 3'd0;
            r_addr      <= 11'd0;
            r_remaining <= 9'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            fifo_full   <= 1'b0;
            overflow    <= 1'b0;
            bad_target  <= 1'b0;
            r_pop_valid <= 1'b0;
            r_pop_entry <= '0;
        end else begin
            r_state     <= w_state_next;
            r_target    <= w_target_next;
            r_addr      <= w_addr_next;
            r_remaining <= w_remaining_next;
            r_count     <= w_count_next;
            fifo_full   <= (w_count_next == c_DEPTH);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_pop_entry <= r_mem[r_rd_ptr];
            end
            r_pop_valid <= w_pop;
            if (w_drop) begin
                overflow <= 1'b1;
            end
            if (w_bad_cmd) begin
                bad_target <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_target, r_addr, write_data};
        end
    end

    assign w_pop_tgt  = r_pop_entry[45:43];
    assign w_pop_addr = r_pop_entry[42:32];
    assign w_pop_data = r_pop_entry[31:0];

    // Address/data ports keep their last value; only the strobes return to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_tile_buffer             <= 1'b0;
            rw_tile_graphics           <= 1'b0;
            rw_sprite_graphics         <= 1'b0;
            rw_color_palettes          <= 1'b0;
            rw_OAM                     <= 1'b0;
            addr_tile_buffer           <= 9'd0;
            addr_tile_graphics         <= 11'd0;
            addr_sprite_graphics       <= 11'd0;
            addr_color_palettes        <= 3'd0;
            addr_OAM                   <= 8'd0;
            write_data_tile_buffer     <= 32'd0;
            write_data_tile_graphics   <= 32'd0;
            write_data_sprite_graphics <= 32'd0;
            write_data_color_palettes  <= 24'd0;
            write_data_OAM             <= 32'd0;
        end else begin
            rw_tile_buffer     <= 1'b0;
            rw_tile_graphics   <= 1'b0;
            rw_sprite_graphics <= 1'b0;
            rw_color_palettes  <= 1'b0;
            rw_OAM             <= 1'b0;
            if (r_pop_valid) begin
                case (w_pop_tgt)
                    3'd0: begin
                        rw_tile_buffer         <= 1'b1;
                        addr_tile_buffer       <= w_pop_addr[8:0];
                        write_data_tile_buffer <= w_pop_data;
                    end
                    3'd1: begin
                        rw_tile_graphics         <= 1'b1;
                        addr_tile_graphics       <= w_pop_addr;
                        write_data_tile_graphics <= w_pop_data;
                    end
                    3'd2: begin
                        rw_sprite_graphics         <= 1'b1;
                        addr_sprite_graphics       <= w_pop_addr;
                        write_data_sprite_graphics <= w_pop_data;
                    end
                    3'd3: begin
                        rw_color_palettes         <= 1'b1;
                        addr_color_palettes       <= w_pop_addr[2:0];
                        write_data_color_palettes <= w_pop_data[23:0];
                    end
                    3'd4: begin
                        rw_OAM         <= 1'b1;
                        addr_OAM       <= w_pop_addr[7:0];
                        write_data_OAM <= w_pop_data;
                    end
                    default: begin
                        rw_OAM <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
